// File: rtl/i2c_target_rx_if.sv
// I2C pin bundle between a bus driver (master side) and the write-only target receiver.
interface i2c_target_rx_if;
  logic i2c_scl_in;
  logic i2c_sda_in;
  logic sda_oe;

  modport master (output i2c_scl_in, output i2c_sda_in, input sda_oe);
  modport slave  (input i2c_scl_in, input i2c_sda_in, output sda_oe);
endinterface

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: oversampled START/STOP detection, address match with ACK,
// register pointer then auto-incrementing data writes into a small register file.
//   state      | meaning
//   S_IDLE     | bus free or not addressed; wait for START
//   S_ADDR     | shifting in {addr, rw}
//   S_ADDR_ACK | driving ACK for a matching address
//   S_PTR      | shifting in the register pointer byte
//   S_PTR_ACK  | driving ACK for the pointer byte
//   S_DATA     | shifting in a data byte
//   S_DATA_ACK | driving ACK for a data byte (write already committed)
module i2c_target_rx #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16,
  parameter int         REG_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  i2c_target_rx_if.slave    bus,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              nack_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK, S_DATA, S_DATA_ACK
  } state_e;

  state_e            state_q, state_d;
  logic              scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_p_q, scl_p_d;
  logic              sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_p_q, sda_p_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              nack_q, nack_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];

  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_rise = scl_s2_q & ~scl_p_q;
  assign scl_fall = ~scl_s2_q & scl_p_q;
  // SCL must be high on both samples so an SDA move coinciding with an SCL edge is not a condition
  assign start_ev = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;

  always_comb begin
    scl_s1_d  = bus.i2c_scl_in;
    scl_s2_d  = scl_s1_q;
    scl_p_d   = scl_s2_q;
    sda_s1_d  = bus.i2c_sda_in;
    sda_s2_d  = sda_s1_q;
    sda_p_d   = sda_s2_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    nack_d    = nack_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d    = regs_q;
    rd_data_d = regs_q[rd_addr];

    if (stop_ev) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_ev) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      nack_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_DATA: begin
          // full byte is acted on the clk after the 8th SCL rise, well before the next SCL fall
          if (bit_cnt_q == 4'd8) begin
            if (state_q == S_ADDR) begin
              if (shift_q == {DEV_ADDR, 1'b0}) begin
                busy_d  = 1'b1;
                state_d = S_ADDR_ACK;
              end else begin
                nack_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end
            end else if (state_q == S_PTR) begin
              ptr_d   = shift_q[REG_AW-1:0];
              state_d = S_PTR_ACK;
            end else begin
              regs_d[ptr_q] = shift_q;
              wr_en_d       = 1'b1;
              wr_addr_d     = ptr_q;
              wr_data_d     = shift_q;
              ptr_d         = ptr_q + REG_AW'(1);
              state_d       = S_DATA_ACK;
            end
          end else if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s2_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_DATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b1;
            end else if (bit_cnt_q == 4'd9) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = (state_q == S_ADDR_ACK) ? S_PTR : S_DATA;
            end
          end else if (scl_rise && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd9;
          end
        end
        default: ;
      endcase
    end
  end

  // synchronizers reset to the idle-bus level so reset release never looks like an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      sda_p_q   <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      nack_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      rd_data_q <= 8'h00;
      regs_q    <= '{default: 8'h00};
    end else begin
      scl_s1_q  <= scl_s1_d;
      scl_s2_q  <= scl_s2_d;
      scl_p_q   <= scl_p_d;
      sda_s1_q  <= sda_s1_d;
      sda_s2_q  <= sda_s2_d;
      sda_p_q   <= sda_p_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      nack_q    <= nack_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      regs_q    <= regs_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign nack_err   = nack_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-banged I2C master, transaction-level reference model,
// write scoreboard checked by an independent monitor.
module tb_i2c_target_rx;
  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl, m_sda;
  logic       wr_en, busy, nack_err;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  always #5 clk = ~clk;

  i2c_target_rx_if bus ();
  assign bus.i2c_scl_in = m_scl;
  assign bus.i2c_sda_in = m_sda & ~bus.sda_oe;

  i2c_target_rx #(.DEV_ADDR(7'h50), .NUM_REGS(16), .REG_AW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .nack_err (nack_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t exp_q[$];

  // Transaction-level model: what phase of a write we are in, the pointer and the register image.
  localparam int PH_ADDR = 0, PH_PTR = 1, PH_DATA = 2, PH_IGNORE = 3;
  logic [7:0] mdl_regs [16];
  logic [3:0] mdl_ptr;
  int         mdl_phase;
  logic       mdl_busy, mdl_nack;

  int   cyc = 0;
  int   fall_cyc = 0;
  logic oe_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    foreach (mdl_regs[i]) mdl_regs[i] = 8'h00;
    mdl_ptr   = 4'd0;
    mdl_phase = PH_IGNORE;
    mdl_busy  = 1'b0;
    mdl_nack  = 1'b0;
  endfunction

  function automatic logic mdl_byte(input logic [7:0] b);
    wr_t e;
    case (mdl_phase)
      PH_ADDR: begin
        if (b == 8'hA0) begin
          mdl_busy = 1'b1; mdl_phase = PH_PTR; return 1'b1;
        end
        mdl_nack = 1'b1; mdl_busy = 1'b0; mdl_phase = PH_IGNORE; return 1'b0;
      end
      PH_PTR: begin
        mdl_ptr = b[3:0]; mdl_phase = PH_DATA; return 1'b1;
      end
      PH_DATA: begin
        mdl_regs[mdl_ptr] = b;
        e.a = mdl_ptr; e.d = b;
        exp_q.push_back(e);
        mdl_ptr = mdl_ptr + 4'd1;
        return 1'b1;
      end
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: write scoreboard and sda_oe edge placement relative to SCL falls.
  always @(posedge clk) begin
    wr_t e;
    #1;
    cyc++;
    if (reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
        end
      end
      if (bus.sda_oe !== oe_prev) begin
        chk("oe_edge_delay", cyc - fall_cyc, 3);
        chk("oe_edge_scl_low", m_scl, 1'b0);
      end
    end
    oe_prev = bus.sda_oe;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_set(input logic v);
    m_scl = v;
    if (!v) fall_cyc = cyc;
  endtask

  task automatic do_start();
    if (!m_scl) begin
      clks(4); m_sda = 1'b1; clks(4); scl_set(1'b1); clks(8);
    end
    m_sda = 1'b0;
    clks(8);
    scl_set(1'b0);
    mdl_phase = PH_ADDR;
    mdl_nack  = 1'b0;
    chk("nack_after_start", nack_err, mdl_nack);
  endtask

  task automatic send_bit(input logic b);
    clks(4); m_sda = b; clks(4); scl_set(1'b1); clks(8); scl_set(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic exp_ack, ack;
    exp_ack = mdl_byte(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    clks(4); m_sda = 1'b1; clks(4); scl_set(1'b1);
    clks(4); ack = (bus.i2c_sda_in == 1'b0);
    clks(4); scl_set(1'b0);
    chk("ack", ack, exp_ack);
    chk("busy", busy, mdl_busy);
    chk("nack_err", nack_err, mdl_nack);
  endtask

  task automatic do_stop();
    clks(4); m_sda = 1'b0; clks(4); scl_set(1'b1); clks(8); m_sda = 1'b1; clks(8);
    mdl_phase = PH_IGNORE;
    mdl_busy  = 1'b0;
    chk("busy_after_stop", busy, mdl_busy);
    chk("nack_after_stop", nack_err, mdl_nack);
  endtask

  task automatic rd_chk(input logic [3:0] a);
    rd_addr = a;
    clks(2);
    chk("rd_data", rd_data, mdl_regs[a]);
  endtask

  task automatic rd_const(input logic [3:0] a, input logic [7:0] v);
    rd_addr = a;
    clks(2);
    chk("rd_const", rd_data, v);
  endtask

  initial begin
    logic [7:0] b;
    int n;
    reset = 1'b0; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 4'd0;
    mdl_reset();
    clks(5);
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    reset = 1'b1;
    clks(10);

    // 1: single write
    do_start(); send_byte(8'hA0); send_byte(8'h03); send_byte(8'h5A); do_stop();
    rd_const(4'd3, 8'h5A);

    // 2: pointer wrap
    do_start(); send_byte(8'hA0); send_byte(8'h0E);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); do_stop();
    rd_const(4'd0, 8'h33); rd_chk(4'd1); rd_chk(4'd14); rd_chk(4'd15);

    // 3: wrong address
    do_start(); send_byte(8'hA2); do_stop();

    // 4: read request, then a valid write
    do_start(); send_byte(8'hA1);
    do_start(); send_byte(8'hA0); send_byte(8'h02); send_byte(8'h77); do_stop();
    rd_const(4'd2, 8'h77);

    // 5: partial byte discarded
    do_start(); send_byte(8'hA0); send_byte(8'h04);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    do_stop();
    rd_chk(4'd4);

    // 6: repeated START keeps only the second transfer's write
    do_start(); send_byte(8'hA0); send_byte(8'h05);
    do_start(); send_byte(8'hA0); send_byte(8'h09); send_byte(8'hC3); do_stop();
    rd_const(4'd9, 8'hC3);

    // randomized transfers
    for (int t = 0; t < 20; t++) begin
      b = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hA0;
      do_start(); send_byte(b);
      send_byte(8'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        do_start(); send_byte(8'hA0); send_byte(8'($urandom));
      end
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) send_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 7);
        for (int k = 0; k < n; k++) send_bit(1'($urandom));
      end
      do_stop();
    end
    for (int a = 0; a < 16; a++) rd_chk(4'(a));

    // reset dropped mid-byte aborts everything
    rd_addr = 4'd9;
    do_start(); send_byte(8'hA0); send_byte(8'h06);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b0;
    clks(1);
    chk("mid_rst_sda_oe", bus.sda_oe, 1'b0);
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_nack", nack_err, 1'b0);
    chk("mid_rst_wr_addr", wr_addr, 4'd0);
    chk("mid_rst_wr_data", wr_data, 8'h00);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    m_scl = 1'b1; m_sda = 1'b1;
    clks(4);
    reset = 1'b1;
    mdl_reset();
    clks(10);
    rd_chk(4'd9);
    do_start(); send_byte(8'hA0); send_byte(8'h07); send_byte(8'h3C); do_stop();
    rd_const(4'd7, 8'h3C);

    clks(10);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
